// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed hex display scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex2seg.sv
// Combinational nibble-to-seven-segment decoder with a blanking override.
module hex2seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_HEX[nibble];
  end

endmodule

// File: rtl/hex_scan_display.sv
// Multi-channel hex scanner: snapshots one channel per frame and multiplexes
// its nibbles onto an active-low 7-segment digit array.
module hex_scan_display
  import disp_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 32,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int ROT_DIV  = 200,
  parameter int BLANK_LZ = 1
) (
  input  logic                        clk_100MHz_i,
  input  logic                        rst_n,
  input  logic [NUM_CH*CH_W-1:0]      cnt_val_i,
  input  logic                        mode_i,
  input  logic [$clog2(NUM_CH)-1:0]   ch_sel_i,
  input  logic                        hold_i,
  output logic [7:0]                  HEX_o,
  output logic [DIGITS-1:0]           AN_o,
  output logic [$clog2(NUM_CH)-1:0]   ch_o,
  output logic                        frame_o
);

  localparam int CH_SEL_W = $clog2(NUM_CH);
  localparam int PS_W     = $clog2(SCAN_DIV);
  localparam int DIG_W    = $clog2(DIGITS);
  localparam int FC_W     = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam int NIB      = CH_W / 4;

  if (CH_W % 4 != 0) begin : g_chk_ch_w_nibble
    $error("CH_W must be a multiple of 4");
  end
  if (CH_W > 4 * DIGITS) begin : g_chk_ch_w_fits
    $error("CH_W must not exceed 4*DIGITS");
  end

  logic [PS_W-1:0]     prescaler;
  logic [DIG_W-1:0]    digit;
  logic [FC_W-1:0]     frame_cnt;
  logic [CH_W-1:0]     snap;
  mode_e               mode_q;
  mode_e               mode_in;
  logic                tick;
  logic                frame_end;
  logic [CH_SEL_W-1:0] ch_next;
  logic [FC_W-1:0]     frame_cnt_next;
  logic [4*DIGITS-1:0] snap_wide;
  logic [DIGITS-1:0]   upper_zero;
  logic                zero_acc;
  logic [3:0]          nibble;
  logic                blank;
  logic [6:0]          seg;
  logic                dp;

  assign mode_in   = mode_e'(mode_i);
  assign tick      = (prescaler == PS_W'(SCAN_DIV - 1));
  assign frame_end = tick && (digit == DIG_W'(DIGITS - 1));

  // Channel/dwell decision for the coming frame. Entering auto mode restarts
  // the dwell without stepping the channel.
  always_comb begin
    ch_next        = ch_o;
    frame_cnt_next = frame_cnt;
    if (mode_in == MODE_AUTO) begin
      if (mode_q == MODE_MANUAL) begin
        frame_cnt_next = '0;
      end else if (frame_cnt == FC_W'(ROT_DIV - 1)) begin
        frame_cnt_next = '0;
        ch_next = (ch_o == CH_SEL_W'(NUM_CH - 1)) ? '0 : ch_o + CH_SEL_W'(1);
      end else begin
        frame_cnt_next = frame_cnt + FC_W'(1);
      end
    end else begin
      frame_cnt_next = '0;
      ch_next = (32'(ch_sel_i) >= NUM_CH) ? CH_SEL_W'(NUM_CH - 1) : ch_sel_i;
    end
  end

  // upper_zero[d] is set when nibble d and every nibble above it are zero.
  always_comb begin
    snap_wide  = (4 * DIGITS)'(snap);
    upper_zero = '0;
    zero_acc   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (snap_wide[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_acc;
    end
    nibble = snap_wide[4*digit +: 4];
    blank  = (32'(digit) >= NIB) ||
             ((BLANK_LZ != 0) && (digit != '0) && upper_zero[digit]);
    dp     = !((digit == '0) && (mode_q == MODE_AUTO));
  end

  hex2seg u_hex2seg (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg)
  );

  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      snap      <= '0;
      mode_q    <= MODE_MANUAL;
      ch_o      <= '0;
      frame_o   <= 1'b0;
      AN_o      <= '1;
      HEX_o     <= 8'hFF;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        digit <= (digit == DIG_W'(DIGITS - 1)) ? '0 : digit + DIG_W'(1);
      end
      frame_o <= frame_end;
      AN_o    <= ~(DIGITS'(1) << digit);
      HEX_o   <= {dp, seg};
      if (frame_end) begin
        mode_q    <= mode_in;
        frame_cnt <= frame_cnt_next;
        ch_o      <= ch_next;
        if (!hold_i) begin
          snap <= cnt_val_i[ch_next*CH_W +: CH_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with a 32-cycle frame (8 digits x 4).
module tb_hex_scan_display;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 16;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int ROT_DIV  = 2;

  typedef struct packed {
    logic [1:0]  ch_sel;
    logic [15:0] v3;
    logic [15:0] v2;
    logic [15:0] v1;
    logic [15:0] v0;
    logic [63:0] exp_hex;  // byte d = expected HEX_o on digit d
    logic [1:0]  exp_ch;
  } vec_t;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH*CH_W-1:0]   cnt_val;
  logic                     mode;
  logic [1:0]               ch_sel;
  logic                     hold;
  logic [7:0]               hex;
  logic [DIGITS-1:0]        an;
  logic [1:0]               ch;
  logic                     frame;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got [8];
  logic [31:0] exp_q [$];
  vec_t       vecs [6];

  hex_scan_display #(
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .ROT_DIV  (ROT_DIV),
    .BLANK_LZ (1)
  ) dut (
    .clk_100MHz_i (clk),
    .rst_n        (rst_n),
    .cnt_val_i    (cnt_val),
    .mode_i       (mode),
    .ch_sel_i     (ch_sel),
    .hold_i       (hold),
    .HEX_o        (hex),
    .AN_o         (an),
    .ch_o         (ch),
    .frame_o      (frame)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic set_vals(input logic [15:0] v0, input logic [15:0] v1,
                          input logic [15:0] v2, input logic [15:0] v3);
    cnt_val = {v3, v2, v1, v0};
  endtask

  // Advance to the negedge at which frame_o is high (bounded).
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 100);
    check({tag, "_frame"}, {31'd0, frame}, 32'd1);
  endtask

  // Record one full frame of HEX_o per digit, indexed by the active AN bit.
  task automatic capture_frame();
    for (int d = 0; d < 8; d++) got[d] = 8'h00;
    for (int n = 0; n < DIGITS * SCAN_DIV; n++) begin
      @(negedge clk);
      for (int d = 0; d < DIGITS; d++) begin
        if (an[d] == 1'b0) got[d] = hex;
      end
    end
  endtask

  task automatic compare_frame(input string tag, input logic [63:0] exp_hex);
    for (int d = 0; d < 8; d++) begin
      check($sformatf("%s_dig%0d", tag, d), {24'd0, got[d]}, {24'd0, exp_hex[8*d +: 8]});
    end
  endtask

  // Count negedges from reset release to the first frame_o; expect 32.
  task automatic check_first_frame(input string tag);
    int n;
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 100);
    check({tag, "_first_frame_len"}, n, 32);
  endtask

  initial begin
    vecs[0] = '{ch_sel: 2'd2, v0: 16'h1111, v1: 16'h2222, v2: 16'h0A3F, v3: 16'h3333,
                exp_hex: 64'hFFFF_FFFF_FF88_B08E, exp_ch: 2'd2};
    vecs[1] = '{ch_sel: 2'd3, v0: 16'h4444, v1: 16'h5555, v2: 16'h6666, v3: 16'h0000,
                exp_hex: 64'hFFFF_FFFF_FFFF_FFC0, exp_ch: 2'd3};
    vecs[2] = '{ch_sel: 2'd0, v0: 16'h1234, v1: 16'h4321, v2: 16'h7777, v3: 16'h8888,
                exp_hex: 64'hFFFF_FFFF_F9A4_B099, exp_ch: 2'd0};
    vecs[3] = '{ch_sel: 2'd1, v0: 16'h9999, v1: 16'hF00E, v2: 16'h1111, v3: 16'h2222,
                exp_hex: 64'hFFFF_FFFF_8EC0_C086, exp_ch: 2'd1};
    vecs[4] = '{ch_sel: 2'd2, v0: 16'h3333, v1: 16'h4444, v2: 16'h0100, v3: 16'h5555,
                exp_hex: 64'hFFFF_FFFF_FFF9_C0C0, exp_ch: 2'd2};
    vecs[5] = '{ch_sel: 2'd1, v0: 16'hABCD, v1: 16'h0008, v2: 16'hDCBA, v3: 16'h1357,
                exp_hex: 64'hFFFF_FFFF_FFFF_FF80, exp_ch: 2'd1};

    // reset
    rst_n = 1'b0; mode = 1'b0; ch_sel = 2'd0; hold = 1'b0; cnt_val = '0;
    repeat (3) @(negedge clk);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_hex", {24'd0, hex}, 32'hFF);
    check("rst_frame", {31'd0, frame}, 32'd0);
    check("rst_ch", {30'd0, ch}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_an", {24'd0, an}, 32'hFE);
    check("rel_hex", {24'd0, hex}, 32'hC0);
    check_first_frame("rel");

    // manual selection table
    for (int i = 0; i < 6; i++) begin
      ch_sel = vecs[i].ch_sel;
      set_vals(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
      wait_frame($sformatf("vec%0d", i));
      check($sformatf("vec%0d_ch", i), {30'd0, ch}, {30'd0, vecs[i].exp_ch});
      capture_frame();
      compare_frame($sformatf("vec%0d", i), vecs[i].exp_hex);
    end

    // hold: snapshot frozen while the channel still follows ch_sel
    ch_sel = 2'd0; hold = 1'b0;
    set_vals(16'h1234, 16'h1111, 16'h2222, 16'h3333);
    wait_frame("hold_pre");
    hold = 1'b1; ch_sel = 2'd1;
    set_vals(16'h5678, 16'hABCD, 16'h2222, 16'h3333);
    wait_frame("hold_on");
    check("hold_on_ch", {30'd0, ch}, 32'd1);
    capture_frame();
    compare_frame("hold_on", 64'hFFFF_FFFF_F9A4_B099);
    hold = 1'b0; ch_sel = 2'd0;
    wait_frame("hold_off");
    check("hold_off_ch", {30'd0, ch}, 32'd0);
    capture_frame();
    compare_frame("hold_off", 64'hFFFF_FFFF_9282_F880);

    // reset at cycle 13 of a frame
    ch_sel = 2'd2;
    set_vals(16'h1111, 16'h2222, 16'h0A3F, 16'h3333);
    wait_frame("mid_pre");
    check("mid_pre_ch", {30'd0, ch}, 32'd2);
    repeat (13) @(negedge clk);
    check("mid_pre_an", {24'd0, an}, 32'hF7);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_an", {24'd0, an}, 32'hFF);
    check("mid_rst_hex", {24'd0, hex}, 32'hFF);
    check("mid_rst_ch", {30'd0, ch}, 32'd0);
    check("mid_rst_frame", {31'd0, frame}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_an", {24'd0, an}, 32'hFE);
    check("mid_rel_hex", {24'd0, hex}, 32'hC0);
    check_first_frame("mid");
    check("mid_post_ch", {30'd0, ch}, 32'd2);

    // auto rotation from reset
    rst_n = 1'b0; mode = 1'b1;
    set_vals(16'h00C5, 16'h1111, 16'h2222, 16'h3333);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int p = 0; p < 9; p++) begin
      wait_frame($sformatf("auto%0d", p));
      check($sformatf("auto%0d_ch", p), {30'd0, ch}, exp_q.pop_front());
    end
    capture_frame();
    compare_frame("auto_dp", 64'hFFFF_FFFF_FFFF_C612);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
